// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-masked, word-organised data memory.
// Accepts one RV32I load/store at a time, rejects misaligned, out-of-range or illegal-funct3
// requests without touching memory, and returns sign/zero-extended load data.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_*                request handshake (valid/ready), store flag, funct3, byte address, data
//   rsp_*                one-cycle response pulse with extended load data and error flag
//   mem_*                memory address, read strobe, byte write mask, write data, read data
//                        (read data is valid the cycle after the strobe)
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 4194304,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rstrb_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e      state_q;
  logic        req_we_q;
  logic [2:0]  req_funct3_q;
  logic [1:0]  req_off_q;

  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready_o = (state_q == StIdle);

  // Request checks, evaluated on the raw inputs at the accept edge.
  always_comb begin
    if (req_we_i) begin
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    // Shift form stays valid even when ADDR_WIDTH reaches 32.
    out_of_range = ((req_addr_i >> ADDR_WIDTH) != 32'd0);
    req_err      = !f3_legal || misaligned || out_of_range;
  end

  // Store lane placement: data replicated across lanes, mask selects the target bytes.
  always_comb begin
    unique case (req_funct3_i[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << req_addr_i[1:0];
        st_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {req_addr_i[1], 1'b0};
        st_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = req_wdata_i;
      end
    endcase
  end

  // Load extraction from the memory word using the registered offset and size code.
  always_comb begin
    unique case (req_off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = req_off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (req_funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Outputs are registered on the edge that enters the state in which they are valid, so
  // strobes and masks are high exactly during ACCESS and drop the moment reset asserts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      req_we_q     <= 1'b0;
      req_funct3_q <= 3'd0;
      req_off_q    <= 2'd0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= 32'd0;
      rsp_err_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_rstrb_o  <= 1'b0;
      mem_wmask_o  <= 4'd0;
      mem_wdata_o  <= 32'd0;
    end else begin
      rsp_valid_o <= 1'b0;
      mem_rstrb_o <= 1'b0;
      mem_wmask_o <= 4'd0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            req_we_q     <= req_we_i;
            req_funct3_q <= req_funct3_i;
            req_off_q    <= req_addr_i[1:0];
            if (req_err) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 32'd0;
              state_q     <= StResp;
            end else begin
              mem_addr_o  <= req_addr_i[ADDR_WIDTH-1:0];
              mem_rstrb_o <= !req_we_i;
              if (req_we_i) begin
                mem_wmask_o <= st_mask;
                mem_wdata_o <= st_wdata;
              end
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (req_we_q) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'd0;
            state_q     <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= ld_data;
          state_q     <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
